// File: rtl/knn_nd_sorter.sv
// k-nearest-neighbour engine: pipelined N-D squared distance feeding a HW_K-deep insertion sorter.
// Define KNN_LABEL_EN to carry a per-sample label through the pipeline and the list.
module knn_nd_sorter #(
  parameter int unsigned DW    = 16,
  parameter int unsigned NDIM  = 2,
  parameter int unsigned HW_K  = 10,
  parameter int unsigned IDXW  = 16,
  parameter int unsigned LBLW  = 8,
  localparam int unsigned DISTW = 2 * DW + 1 + $clog2(NDIM),
  localparam int unsigned KW    = (HW_K > 1) ? $clog2(HW_K) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NDIM*DW-1:0] test_x,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [NDIM*DW-1:0] train_x,
`ifdef KNN_LABEL_EN
  input  logic [LBLW-1:0]    train_lbl,
`endif
  output logic               done,
  output logic               busy,
  output logic [KW:0]        fill,
  input  logic [KW-1:0]      rd_sel,
  output logic [DISTW-1:0]   rd_dist,
  output logic [IDXW-1:0]    rd_idx
`ifdef KNN_LABEL_EN
  ,
  output logic [LBLW-1:0]    rd_lbl
`endif
);

  localparam int unsigned LVL = $clog2(NDIM);
  localparam int unsigned LAT = 2 + LVL;
  localparam int unsigned NP  = 1 << LVL;
  localparam int unsigned NN  = 2 * NP - 1;
  localparam logic [KW:0] KFull = (KW + 1)'(HW_K);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;
  state_e state_q, state_d;

  logic                 clear, accept, pipe_busy;
  logic [IDXW-1:0]      cnt_q;
  logic [NDIM*DW-1:0]   test_q;
  logic signed [DW:0]   diff_d [NDIM];
  logic signed [DW:0]   diff_q [NDIM];
  logic [DISTW-1:0]     leaf [NP];
  // Heap-ordered adder tree: node n sums nodes 2n+1 and 2n+2, leaves start at NP-1.
  logic [DISTW-1:0]     node_q [NN];
  logic                 v_q [LAT];
  logic [IDXW-1:0]      pidx_q [LAT];
  logic [DISTW-1:0]     sd_q [HW_K];
  logic [IDXW-1:0]      si_q [HW_K];
  logic [DISTW-1:0]     sh_d [HW_K];
  logic [IDXW-1:0]      sh_i [HW_K];
  logic [HW_K-1:0]      lt, lt_prev;
  logic [KW:0]          fill_q;
`ifdef KNN_LABEL_EN
  logic [LBLW-1:0]      plbl_q [LAT];
  logic [LBLW-1:0]      sl_q [HW_K];
  logic [LBLW-1:0]      sh_l [HW_K];
`endif

  assign accept = in_valid & (state_q == StRun);
  assign fill   = fill_q;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < LAT - 1; i++) pipe_busy = pipe_busy | v_q[i];
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      StIdle: if (start) begin
        clear   = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (in_last || cnt_q == '1)) state_d = StFlush;
      end
      StFlush: begin
        busy = 1'b1;
        if (!pipe_busy) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          clear   = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int i = 0; i < LAT; i++) v_q[i] <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + 1'b1;
      v_q[0] <= accept;
      for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
    end
  end

  always_comb begin
    for (int d = 0; d < NDIM; d++) begin
      diff_d[d] = $signed({train_x[d*DW+DW-1], train_x[d*DW +: DW]})
                - $signed({test_q[d*DW+DW-1], test_q[d*DW +: DW]});
    end
  end

  always_comb begin
    logic signed [2*DW+1:0] dx, prod;
    for (int p = 0; p < NP; p++) leaf[p] = '0;
    for (int d = 0; d < NDIM; d++) begin
      dx      = (2 * DW + 2)'(diff_q[d]);
      prod    = dx * dx;
      leaf[d] = DISTW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) test_q <= test_x;
    for (int d = 0; d < NDIM; d++) diff_q[d] <= diff_d[d];
    for (int p = 0; p < NP; p++) node_q[NP-1+p] <= leaf[p];
    for (int n = 0; n < int'(NP) - 1; n++) node_q[n] <= node_q[2*n+1] + node_q[2*n+2];
    pidx_q[0] <= cnt_q;
    for (int i = 1; i < LAT; i++) pidx_q[i] <= pidx_q[i-1];
`ifdef KNN_LABEL_EN
    plbl_q[0] <= train_lbl;
    for (int i = 1; i < LAT; i++) plbl_q[i] <= plbl_q[i-1];
`endif
  end

  // List stays sorted, so lt is a thermometer: the first set bit is the insert rank.
  always_comb begin
    for (int r = 0; r < HW_K; r++) lt[r] = v_q[LAT-1] && (node_q[0] < sd_q[r]);
    lt_prev = lt << 1;
    sh_d[0] = node_q[0];
    sh_i[0] = pidx_q[LAT-1];
    for (int r = 1; r < HW_K; r++) begin
      sh_d[r] = sd_q[r-1];
      sh_i[r] = si_q[r-1];
    end
`ifdef KNN_LABEL_EN
    sh_l[0] = plbl_q[LAT-1];
    for (int r = 1; r < HW_K; r++) sh_l[r] = sl_q[r-1];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      fill_q <= '0;
      for (int r = 0; r < HW_K; r++) begin
        sd_q[r] <= '1;
        si_q[r] <= '1;
`ifdef KNN_LABEL_EN
        sl_q[r] <= '0;
`endif
      end
    end else if (lt[HW_K-1]) begin
      if (fill_q != KFull) fill_q <= fill_q + 1'b1;
      for (int r = 0; r < HW_K; r++) begin
        if (lt[r]) begin
          sd_q[r] <= lt_prev[r] ? sh_d[r] : node_q[0];
          si_q[r] <= lt_prev[r] ? sh_i[r] : pidx_q[LAT-1];
`ifdef KNN_LABEL_EN
          sl_q[r] <= lt_prev[r] ? sh_l[r] : plbl_q[LAT-1];
`endif
        end
      end
    end
  end

  always_comb begin
    rd_dist = '1;
    rd_idx  = '1;
`ifdef KNN_LABEL_EN
    rd_lbl  = '0;
`endif
    if (32'(rd_sel) < HW_K) begin
      rd_dist = sd_q[rd_sel];
      rd_idx  = si_q[rd_sel];
`ifdef KNN_LABEL_EN
      rd_lbl  = sl_q[rd_sel];
`endif
    end
  end

endmodule

// File: doc/knn_nd_sorter.md
# knn_nd_sorter

Parametrised k-nearest-neighbour engine for the KNN accelerator. It streams training points of NDIM signed coordinates against a test point latched at start. A pipelined squared-Euclidean distance unit feeds an insertion sorter that keeps the HW_K nearest (distance, index) pairs. It generalises the fixed 2-D distance/sorter pair to N dimensions and adds a valid/ready handshake, a run/flush/done state machine and random-access result readout.

## Interface
- DW, 16: signed coordinate width.
- NDIM, 2: dimensions per point (≥1).
- HW_K, 10: list depth (≥1).
- IDXW, 16: training index width.
- LBLW, 8: label width (used only with KNN_LABEL_EN).
- Derived: DISTW = 2*DW+1+$clog2(NDIM); LAT = 2+$clog2(NDIM); KW = max(1,$clog2(HW_K)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; latches test_x, clears list and index counter.
- test_x  in  NDIM*DW  test point, coordinate d at bits [d*DW +: DW].
- in_valid  in  1  training sample valid.
- in_ready  out  1  sample accepted when in_valid&in_ready.
- in_last  in  1  qualifies the final sample.
- train_x  in  NDIM*DW  training point, same packing.
- train_lbl  in  LBLW  sample label (KNN_LABEL_EN only).
- done  out  1  list final; held until next start.
- busy  out  1  high in RUN and FLUSH.
- fill  out  KW+1  occupied slots, saturates at HW_K.
- rd_sel  in  KW  rank select; 0 = nearest.
- rd_dist  out  DISTW  distance at rank rd_sel (combinational).
- rd_idx  out  IDXW  training index at rank rd_sel.
- rd_lbl  out  LBLW  label at rank rd_sel (KNN_LABEL_EN only).

## Operation
- States: IDLE → (start) RUN → (accept with in_last, or index counter reaching 2^IDXW-1 on accept) FLUSH → (pipeline and sorter input empty) DONE → (start) RUN.
- start is honoured in IDLE and DONE only; it is ignored in RUN and FLUSH.
- On start, all slots are set to dist = all-ones, idx = all-ones, lbl = 0. fill, the index counter and done are cleared.
- in_ready = 1 only in RUN. Each accept tags the sample with the current index counter, then increments the counter.
- Distance stages:
  - S1: diff_d = train_x_d − test_x_d, DW+1 bits signed.
  - S2: sq_d = diff_d², 2*DW+1 bits unsigned.
  - Then a registered binary adder tree of $clog2(NDIM) levels with zero-padded odd lanes.
  - No overflow is possible at DISTW bits.
- Insertion: the new pair goes to the first rank r where new_dist < slot[r].dist. Slots r..HW_K-2 shift down one position; slot HW_K-1 is discarded. If no rank qualifies, nothing changes.
- Ties: the earlier index keeps the better rank (strict <).
- A distance equal to all-ones is never inserted. This cannot occur for legal inputs.
- rd_sel ≥ HW_K returns all-ones dist/idx and lbl 0.

## Timing
- Reset values: in_ready 0, done 0, busy 0, fill 0, state IDLE, slots at their cleared values. rd_* reflects the slots.
- Accept at cycle t: distance valid at t+LAT; slot update visible from t+LAT+1.
- Full throughput of one sample per cycle with no bubbles. in_valid low creates pipeline bubbles that are ignored.
- in_last accepted at t: in_ready drops from t+1. done and the final list are visible together at t+LAT+1, and busy falls at the same cycle.
- start at cycle s: slots cleared, in_ready = 1 and busy = 1 from s+1.
- rst asserted mid-run clears state, pipeline valids and slots immediately. In-flight samples are lost.

## Configuration
- KNN_LABEL_EN defined: train_lbl and rd_lbl ports exist; the label travels through the pipeline and sorter alongside idx.
- KNN_LABEL_EN undefined: no label ports or storage; everything else is identical.

## Test plan
- Reset, then NDIM=2, HW_K=4, test_x=(0,0), stream (3,4),(1,1),(−2,0),(5,5),(0,1) with last → rd ranks 0..3: dist 1,2,4,25; idx 4,1,2,0; fill 4; done at accept+LAT+1.
- Ties: test (0,0), stream (1,0),(0,1),(−1,0) → dist 1,1,1 with idx 0,1,2 in that order.
- Extremes: DW=16, test (−32768,−32768), train (32767,32767) → dist 2·65535² = 8589672450, no wrap.
- Two samples with in_last only → fill 2; rd_sel 2,3 read all-ones; start issued during RUN is ignored.
- rst pulsed mid-stream → all outputs at reset values next cycle; a new start runs cleanly.
- NDIM=3, continuous in_valid for 1000 random samples → list matches the reference model and in_ready never drops before last.
